// File: rtl/xpmwrap_spram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, read-tag record
// and the helper that sizes requester ids.
package xpmwrap_spram_arb_pkg;

    // Widest id the tag record carries (NUM_REQ is at most 8).
    localparam int TAG_ID_W = 3;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        CLEAR,
        DRAIN,
        ARB
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/xpmwrap_rr_arb.sv
// Round-robin grant logic with its own pointer register; the pointer moves
// one past the winner after every grant and holds when nothing is granted.
module xpmwrap_rr_arb
    import xpmwrap_spram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int TW      = tag_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [TW-1:0]      grant_id,
    output logic               grant_valid
);

    logic [TW-1:0] ptr_q;
    logic [TW:0]   idx_sum;
    logic [TW-1:0] idx;

    // Scan from the pointer upward, wrapping modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx_sum     = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, ptr_q} + (TW+1)'(k);
            if (idx_sum >= (TW+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (TW+1)'(NUM_REQ);
            end
            idx = idx_sum[TW-1:0];
            if (en && !grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            ptr_q <= (grant_id == TW'(NUM_REQ - 1)) ? '0 : grant_id + TW'(1);
        end
    end

endmodule

// File: rtl/xpmwrap_spram.sv
// Single-port RAM wrapper with a registered read path of READ_LATENCY stages;
// the final stage advances only while regcea is high.
module xpmwrap_spram #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  regcea,
    output logic [DATA_WIDTH-1:0] douta
);

    logic [DATA_WIDTH-1:0] mem    [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end else begin
                pipe_q[0] <= mem[addra];
            end
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            if (regcea) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign douta = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/xpmwrap_spram_arb.sv
// Shares one single-port RAM between NUM_REQ requesters: clears the RAM after
// reset, then grants one access per cycle and routes read data back by tag.
module xpmwrap_spram_arb
    import xpmwrap_spram_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = 2,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                            clka,
    input  logic                            rsta,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            init_done,
    output logic                            ram_ena,
    output logic                            ram_wea,
    output logic [ADDR_WIDTH-1:0]           ram_addra,
    output logic [DATA_WIDTH-1:0]           ram_dina,
    output logic                            ram_regcea,
    input  logic [DATA_WIDTH-1:0]           ram_douta
);

    localparam int                  TW       = tag_width(NUM_REQ);
    localparam int                  DW       = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] CLR_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] clr_q, clr_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                arb_en;
    logic [NUM_REQ-1:0]  grant;
    logic [TW-1:0]       grant_id;
    logic                grant_valid;
    tag_t                push;
    tag_t                tail;
    tag_t                tag_q [RD_LATENCY];

    assign arb_en     = !rsta && (state_q == ARB);
    assign init_done  = arb_en;
    assign req_ready  = grant;
    assign ram_regcea = 1'b1;
    assign rsp_rdata  = ram_douta;

    xpmwrap_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clka),
        .rst         (rsta),
        .en          (arb_en),
        .req         (req_valid),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            drain_q <= drain_d;
        end
    end

    // DRAIN lets the last clear writes settle before anyone can read.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        drain_d = drain_q;
        case (state_q)
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == CLR_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(RD_LATENCY - 1)) begin
                    state_d = ARB;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ARB:     state_d = ARB;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = INIT_VALUE;
        if (!rsta) begin
            case (state_q)
                CLEAR: begin
                    ram_ena   = 1'b1;
                    ram_wea   = 1'b1;
                    ram_addra = clr_q[ADDR_WIDTH-1:0];
                end
                ARB: begin
                    if (grant_valid) begin
                        ram_ena   = 1'b1;
                        ram_wea   = req_we[grant_id];
                        ram_addra = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_dina  = req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    // Each slot of the tag pipe lines up with one stage of the RAM read path.
    always_comb begin
        push.valid = grant_valid && !req_we[grant_id];
        push.id    = TAG_ID_W'(grant_id);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= push;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail = tag_q[RD_LATENCY-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = !rsta && tail.valid && (tail.id == TAG_ID_W'(i));
        end
    end

endmodule

// File: tb/tb_xpmwrap_spram_arb.sv
// Bench for xpmwrap_spram_arb in front of a 2-cycle xpmwrap_spram, checked
// cycle by cycle against a behavioural model of clear, arbitration and reads.
module tb_xpmwrap_spram_arb;

    logic        clka;
    logic        rsta;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        ram_ena;
    logic        ram_wea;
    logic [5:0]  ram_addra;
    logic [31:0] ram_dina;
    logic        ram_regcea;
    logic [31:0] ram_douta;

    xpmwrap_spram_arb #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .RD_LATENCY (2),
        .INIT_VALUE (32'h0)
    ) dut (
        .clka       (clka),
        .rsta       (rsta),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .ram_ena    (ram_ena),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_regcea (ram_regcea),
        .ram_douta  (ram_douta)
    );

    xpmwrap_spram #(
        .ADDR_WIDTH   (6),
        .DATA_WIDTH   (32),
        .READ_LATENCY (2)
    ) u_ram (
        .clka   (clka),
        .ena    (ram_ena),
        .wea    (ram_wea),
        .addra  (ram_addra),
        .dina   (ram_dina),
        .regcea (ram_regcea),
        .douta  (ram_douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          ptr         = 0;
    logic [31:0] mem_model [64];
    rsp_t        rsp_q [$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive after the falling edge, compare against the
    // model shortly after, then advance the model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [1:0] we,
                                 input logic [5:0] a0, input logic [5:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        logic [1:0]  exp_ready;
        logic        exp_ena;
        logic        exp_wea;
        logic [5:0]  exp_addr;
        logic [31:0] exp_din;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_rdata;
        logic        exp_init;
        logic        popped;
        int          g;
        int          idx;
        logic [5:0]  ga;
        logic [31:0] gd;
        logic        gwe;

        @(negedge clka);
        rsta      = rst;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;

        exp_ready = 2'b00;
        exp_ena   = 1'b0;
        exp_wea   = 1'b0;
        exp_addr  = 6'd0;
        exp_din   = 32'h0;
        exp_rsp   = 2'b00;
        exp_rdata = 32'h0;
        exp_init  = 1'b0;
        popped    = 1'b0;
        g         = -1;
        ga        = 6'd0;
        gd        = 32'h0;
        gwe       = 1'b0;

        if (!rst) begin
            if (cyc < 64) begin
                exp_ena  = 1'b1;
                exp_wea  = 1'b1;
                exp_addr = 6'(cyc);
            end else if (cyc >= 66) begin
                exp_init = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    idx = (ptr + k) % 2;
                    if (g < 0 && ((v >> idx) & 2'b01) != 2'b00) g = idx;
                end
                if (g >= 0) begin
                    ga        = (g == 0) ? a0 : a1;
                    gd        = (g == 0) ? d0 : d1;
                    gwe       = ((we >> g) & 2'b01) != 2'b00;
                    exp_ready = 2'b01 << g;
                    exp_ena   = 1'b1;
                    exp_wea   = gwe;
                    exp_addr  = ga;
                    exp_din   = gd;
                end
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                exp_rsp   = 2'b01 << rsp_q[0].id;
                exp_rdata = rsp_q[0].data;
                popped    = 1'b1;
            end
        end

        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("ram_ena", 64'(ram_ena), 64'(exp_ena));
        checkOutput("init_done", 64'(init_done), 64'(exp_init));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (rst || exp_ena) begin
            checkOutput("ram_wea", 64'(ram_wea), 64'(exp_wea));
            checkOutput("ram_addra", 64'(ram_addra), 64'(exp_addr));
        end
        if (exp_ena && exp_wea) checkOutput("ram_dina", 64'(ram_dina), 64'(exp_din));
        if (popped) checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));

        @(posedge clka);
        if (rst) begin
            cyc = 0;
            ptr = 0;
            rsp_q.delete();
        end else begin
            if (cyc < 64) mem_model[cyc] = 32'h0;
            if (popped) void'(rsp_q.pop_front());
            if (g >= 0) begin
                ptr = (g + 1) % 2;
                if (gwe) mem_model[ga] = gd;
                else rsp_q.push_back('{due: cyc + 2, id: g, data: mem_model[ga]});
            end
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    endtask

    initial begin
        rsta      = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;

        $display("[TB] reset and clear sequence");
        applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        // Requester 0 holds a read of addr 9 through clear; granted on the first ARB cycle.
        for (int i = 0; i < 67; i++) applyStimulus(1'b0, 2'b01, 2'b00, 6'd9, 6'd0, 32'h0, 32'h0);
        idle(3);

        $display("[TB] write then read back through the other requester");
        applyStimulus(1'b0, 2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0);
        idle(1);
        applyStimulus(1'b0, 2'b10, 2'b00, 6'd0, 6'd5, 32'h0, 32'h0);
        idle(3);

        $display("[TB] back-to-back reads from both requesters");
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 2'b11, 2'b00, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 32'h0, 32'h0);
        idle(3);

        $display("[TB] requester 1 alone, then both");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 2'b10, 2'b10, 6'd0, 6'(10 + i), 32'h0, $urandom);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 2'b11, 2'b00, 6'(10 + i), 6'(12 - i), 32'h0, 32'h0);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), $urandom, $urandom);
        idle(3);

        $display("[TB] reset while a read is in flight");
        applyStimulus(1'b0, 2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
        for (int i = 0; i < 67; i++) applyStimulus(1'b0, 2'b10, 2'b10, 6'd0, 6'd7, 32'h0, 32'h12345678);
        applyStimulus(1'b0, 2'b11, 2'b00, 6'd5, 6'd7, 32'h0, 32'h0);
        applyStimulus(1'b0, 2'b11, 2'b00, 6'd5, 6'd7, 32'h0, 32'h0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
